// File: rtl/bn_apply.sv
// Batch-norm apply: streams LEN samples per filter through y = sat((x*p + q) >>> FRAC),
// fetching per-filter p/q from an external weight memory before each filter.
module bn_apply #(
  parameter int unsigned NUM_FILTERS = 10,
  parameter int unsigned LEN         = 64,
  parameter int unsigned FRAC        = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               w_start,
  output logic [3:0]         w_filter,
  input  logic signed [15:0] w_p,
  input  logic signed [31:0] w_q,
  input  logic               w_done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic [3:0]         out_filter
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, FIN} state_e;

  localparam logic [15:0]        LastSample = 16'(LEN - 1);
  localparam logic [3:0]         LastFilter = 4'(NUM_FILTERS - 1);
  localparam logic signed [32:0] SatMax     = 33'sd32767;
  localparam logic signed [32:0] SatMin     = -33'sd32768;

  state_e             state_q;
  logic [15:0]        sample_q;
  logic [3:0]         filter_q;
  logic signed [15:0] p_q;
  logic signed [31:0] q_q;

  logic               v1_q;
  logic signed [31:0] prod1_q;
  logic signed [31:0] q1_q;
  logic [3:0]         tag1_q;

  logic               adv;
  logic               xfer;
  logic signed [31:0] prod_n;
  logic signed [32:0] sum_n;
  logic signed [32:0] shr_n;
  logic signed [15:0] sat_n;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !rst && (state_q == RUN) && adv;
  assign xfer     = in_valid && in_ready;
  assign w_filter = filter_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      filter_q <= '0;
      p_q      <= '0;
      q_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      w_start  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sample_q <= '0;
            filter_q <= '0;
            busy     <= 1'b1;
            w_start  <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          if (w_done) begin
            p_q     <= w_p;
            q_q     <= w_q;
            w_start <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (sample_q == LastSample) begin
              sample_q <= '0;
              if (filter_q == LastFilter) begin
                state_q <= DRAIN;
              end else begin
                filter_q <= filter_q + 4'd1;
                w_start  <= 1'b1;
                state_q  <= LOAD;
              end
            end else begin
              sample_q <= sample_q + 16'd1;
            end
          end
        end
        DRAIN: begin
          // Leave as soon as both valids are known to be clear after this edge, so done
          // lands in the cycle right after the last output handshake.
          if (!v1_q && adv) begin
            done    <= 1'b1;
            state_q <= FIN;
          end
        end
        FIN: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prod_n = $signed({{16{in_data[15]}}, in_data}) * $signed({{16{p_q[15]}}, p_q});
  assign sum_n  = $signed({prod1_q[31], prod1_q}) + $signed({q1_q[31], q1_q});
  assign shr_n  = sum_n >>> FRAC;

  always_comb begin
    sat_n = shr_n[15:0];
    if (shr_n > SatMax) begin
      sat_n = 16'sh7fff;
    end else if (shr_n < SatMin) begin
      sat_n = 16'sh8000;
    end
  end

  // q travels with its product so a reload in LOAD cannot touch samples still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      prod1_q    <= '0;
      q1_q       <= '0;
      tag1_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
    end else if (adv) begin
      v1_q       <= xfer;
      prod1_q    <= prod_n;
      q1_q       <= q_q;
      tag1_q     <= filter_q;
      out_valid  <= v1_q;
      out_data   <= sat_n;
      out_filter <= tag1_q;
    end
  end

endmodule

// File: tb/tb_bn_apply.sv
// Bench for bn_apply: a 1x1 instance for arithmetic vectors and a default instance for
// full streaming runs, stalls and mid-run reset, all checked against an arithmetic model.
module tb_bn_apply;

  localparam int Frac = 14;
  localparam int NumF = 10;
  localparam int Len  = 64;
  localparam int NTot = NumF * Len;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Single-filter, single-sample instance
  logic               s_start, s_busy, s_done, s_w_start, s_w_done;
  logic [3:0]         s_w_filter, s_out_filter;
  logic signed [15:0] s_w_p, s_in_data, s_out_data, sp;
  logic signed [31:0] s_w_q, sq;
  logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready;

  assign s_w_done = s_w_start;
  assign s_w_p    = sp;
  assign s_w_q    = sq;

  bn_apply #(.NUM_FILTERS(1), .LEN(1), .FRAC(Frac)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .w_start(s_w_start), .w_filter(s_w_filter), .w_p(s_w_p), .w_q(s_w_q), .w_done(s_w_done),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_filter(s_out_filter)
  );

  // Default-parameter instance
  logic               d_start, d_busy, d_done, d_w_start, d_w_done;
  logic [3:0]         d_w_filter, d_out_filter;
  logic signed [15:0] d_w_p, d_in_data, d_out_data;
  logic signed [31:0] d_w_q;
  logic               d_in_valid, d_in_ready, d_out_valid, d_out_ready;

  logic signed [15:0] dp [16];
  logic signed [31:0] dq [16];
  logic signed [15:0] xs [NTot];
  logic signed [15:0] ref_q [$];

  assign d_w_done = d_w_start;
  assign d_w_p    = dp[d_w_filter];
  assign d_w_q    = dq[d_w_filter];

  bn_apply u_dut (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .w_start(d_w_start), .w_filter(d_w_filter), .w_p(d_w_p), .w_q(d_w_q), .w_done(d_w_done),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_filter(d_out_filter)
  );

  function automatic logic signed [15:0] model(input int p, input int q, input int x);
    longint s;
    s = (longint'(x) * longint'(p) + longint'(q)) >>> Frac;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic gen_data();
    for (int f = 0; f < 16; f++) begin
      dp[f] = 16'($urandom);
      dq[f] = 32'(int'($urandom_range(0, 1 << 27)) - (1 << 26));
    end
    for (int i = 0; i < NTot; i++) xs[i] = 16'($urandom);
  endtask

  // One start/sample/result sequence on the small instance; leaves it back in IDLE.
  task automatic run_small(input int p, input int q, input int x,
                           output logic signed [15:0] got, output logic [3:0] tag,
                           output logic done_next, output bit to);
    bit xfer;
    to = 1'b1; got = '0; tag = '0; done_next = 1'b0;
    sp = 16'(p); sq = 32'(q);
    s_in_data = 16'(x); s_in_valid = 1'b1; s_out_ready = 1'b1; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 30 && to; i++) begin
      if (s_out_valid && s_out_ready) begin
        got = s_out_data; tag = s_out_filter; to = 1'b0;
      end
      xfer = s_in_valid && s_in_ready;
      @(posedge clk); #1;
      if (xfer) s_in_valid = 1'b0;
    end
    done_next = s_done;
    s_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    if (to) begin
      total++; bad++;
      $display("FAIL small_timeout: no output within 30 cycles (x=%0d)", x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({d_busy, d_done, d_w_start, d_in_ready, d_out_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {d_busy, d_done, d_w_start,
                      d_in_ready, d_out_valid});
    end
    total++;
    if ({d_w_filter, d_out_filter, d_out_data} !== 24'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {d_w_filter, d_out_filter, d_out_data});
    end
    total++;
    if ({s_busy, s_done, s_w_start, s_in_ready, s_out_valid, s_out_data} !== 21'h0) begin
      bad++; $display("FAIL reset_small: got %h want 0", {s_busy, s_done, s_w_start,
                      s_in_ready, s_out_valid, s_out_data});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unity();
    logic signed [15:0] got;
    logic [3:0] tag;
    logic dn;
    bit to;
    run_small(16384, 0, 100, got, tag, dn, to);
    total++;
    if (got !== 16'sd100) begin bad++; $display("FAIL unity_data: got %0d want 100", got); end
    total++;
    if (tag !== 4'd0) begin bad++; $display("FAIL unity_tag: got %0d want 0", tag); end
    total++;
    if (dn !== 1'b1) begin bad++; $display("FAIL unity_done: got %b want 1", dn); end
    total++;
    if (s_busy !== 1'b0) begin bad++; $display("FAIL unity_idle_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_vectors();
    int vp [5] = '{10712, -190, 1, 28571, 28571};
    int vq [5] = '{-28612, 721518, 0, -28612, 0};
    int vx [5] = '{1000, -32768, -1, 32767, -32768};
    int ve [5] = '{652, 424, -1, 32767, -32768};
    logic signed [15:0] got;
    logic [3:0] tag;
    logic dn;
    bit to;
    for (int i = 0; i < 5; i++) begin
      run_small(vp[i], vq[i], vx[i], got, tag, dn, to);
      total++;
      if (got !== 16'(ve[i])) begin
        bad++; $display("FAIL vector%0d: got %0d want %0d", i, got, ve[i]);
      end
    end
  endtask

  task automatic test_random_single();
    logic signed [15:0] got, expv;
    logic [3:0] tag;
    logic dn;
    bit to;
    int p, q, x;
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 65535)) - 32768;
      q = int'($urandom_range(0, 1 << 28)) - (1 << 27);
      x = int'($urandom_range(0, 65535)) - 32768;
      expv = model(p, q, x);
      run_small(p, q, x, got, tag, dn, to);
      total++;
      if (got !== expv) begin
        bad++; $display("FAIL rand%0d: p=%0d q=%0d x=%0d got %0d want %0d", i, p, q, x, got, expv);
      end
    end
  endtask

  task automatic test_stream(input bit stall, input bit rec, input string name);
    int idx, oc, wf, dn, stall_cnt;
    bit xfer;
    logic signed [15:0] expv;
    idx = 0; oc = 0; wf = 0; dn = 0; stall_cnt = 0;
    if (rec) ref_q.delete();
    d_out_ready = 1'b1; d_in_valid = 1'b1; d_in_data = xs[0]; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    for (int cyc = 0; cyc < 6000 && dn == 0; cyc++) begin
      if (stall) begin
        if (stall_cnt == 0 && $urandom_range(0, 3) == 0) stall_cnt = $urandom_range(1, 5);
        d_out_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
      end
      #1;
      if (d_w_start && d_w_done) begin
        total++;
        if (d_w_filter !== 4'(wf)) begin
          bad++; $display("FAIL %s_wfilter: got %0d want %0d", name, d_w_filter, wf);
        end
        wf++;
      end
      if (d_out_valid && !d_out_ready) begin
        total++;
        if (d_in_ready !== 1'b0) begin
          bad++; $display("FAIL %s_inready_stall: got %b want 0", name, d_in_ready);
        end
      end
      if (d_out_valid && d_out_ready) begin
        total++;
        if (oc >= NTot) begin
          bad++; $display("FAIL %s_extra_output: got output %0d want at most %0d", name, oc, NTot);
        end else begin
          expv = model(dp[oc / Len], dq[oc / Len], xs[oc]);
          if (d_out_data !== expv || d_out_filter !== 4'(oc / Len)) begin
            bad++;
            $display("FAIL %s_out%0d: got %0d/f%0d want %0d/f%0d", name, oc, d_out_data,
                     d_out_filter, expv, oc / Len);
          end
          if (rec) begin
            ref_q.push_back(d_out_data);
          end else if (stall && oc < ref_q.size()) begin
            total++;
            if (d_out_data !== ref_q[oc]) begin
              bad++; $display("FAIL %s_vs_nostall%0d: got %0d want %0d", name, oc, d_out_data,
                              ref_q[oc]);
            end
          end
        end
        oc++;
      end
      if (d_done) dn++;
      xfer = d_in_valid && d_in_ready;
      @(posedge clk); #1;
      if (xfer) begin
        idx++;
        d_in_data = (idx < NTot) ? xs[idx] : '0;
      end
    end
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    repeat (5) begin
      if (d_done) dn++;
      @(posedge clk); #1;
    end
    total++;
    if (oc != NTot) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, oc, NTot); end
    total++;
    if (wf != NumF) begin bad++; $display("FAIL %s_loads: got %0d want %0d", name, wf, NumF); end
    total++;
    if (dn != 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", name, dn); end
  endtask

  task automatic test_reset_mid_run();
    int tr, dn;
    bit xfer;
    tr = 0; dn = 0;
    d_out_ready = 1'b1; d_in_valid = 1'b1; d_in_data = xs[0]; d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (d_w_filter == 4'd3 && d_in_ready && tr >= 3 * Len + 5) break;
      xfer = d_in_valid && d_in_ready;
      @(posedge clk); #1;
      if (xfer) begin tr++; d_in_data = xs[tr]; end
    end
    total++;
    if (d_w_filter !== 4'd3 || d_in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_reach: got filter %0d ready %b want 3/1", d_w_filter, d_in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({d_busy, d_done, d_w_start, d_in_ready, d_out_valid} !== 5'b0) begin
      bad++; $display("FAIL midrst_ctrl: got %b want 00000", {d_busy, d_done, d_w_start,
                      d_in_ready, d_out_valid});
    end
    total++;
    if ({d_w_filter, d_out_filter, d_out_data} !== 24'h0) begin
      bad++; $display("FAIL midrst_data: got %h want 0", {d_w_filter, d_out_filter, d_out_data});
    end
    rst = 1'b0; d_in_valid = 1'b0;
    repeat (20) begin
      if (d_done) dn++;
      @(posedge clk); #1;
    end
    total++;
    if (dn != 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", dn); end
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1; sp = '0; sq = '0;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
    gen_data();
    test_reset();
    test_unity();
    test_vectors();
    test_random_single();
    test_stream(1'b0, 1'b1, "nostall");
    test_stream(1'b1, 1'b0, "stall");
    test_reset_mid_run();
    test_stream(1'b0, 1'b0, "restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bn_apply.md
BN_APPLY -- requirements
Module: bn_apply

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 10: filters processed per run, 1..16.
REQ-002 SHALL have parameter LEN, default 64: samples per filter, 1..65535.
REQ-003 SHALL have parameter FRAC, default 14: fractional bits of p; result shift amount.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-007 SHALL have port busy, output, 1 bit: high from the accepted start until the done cycle, inclusive.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the last output has been transferred.
REQ-009 SHALL have port w_start, output, 1 bit: weight request to the BN weight memory.
REQ-010 SHALL have port w_filter, output, 4 bits: filter index for the weight request.
REQ-011 SHALL have port w_p, input, signed 16 bits: scale coefficient, Q(16-FRAC).FRAC.
REQ-012 SHALL have port w_q, input, signed 32 bits: offset, already in the x*p domain.
REQ-013 SHALL have port w_done, input, 1 bit: w_p and w_q are valid in this cycle.
REQ-014 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, signed 16): activation stream.
REQ-015 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, signed 16) and out_filter (output, 4): result stream with its filter tag.

Function
REQ-016 SHALL use FSM states IDLE, LOAD, RUN, DRAIN and FIN.
REQ-017 IDLE: start=1 SHALL clear the filter counter and sample counter and enter LOAD; start in any other state SHALL be ignored.
REQ-018 LOAD: SHALL assert w_start=1 with w_filter=filter counter; on w_done=1 SHALL latch w_p/w_q, deassert w_start next cycle and enter RUN (1-cycle LOAD when w_done equals w_start).
REQ-019 RUN: in_ready SHALL be 1 iff state is RUN and adv=1, where adv = !out_valid || out_ready; a transfer is in_valid && in_ready.
REQ-020 On the LEN-th transfer of a filter: SHALL clear the sample counter, increment the filter counter and go to LOAD, or to DRAIN if that was filter NUM_FILTERS-1.
REQ-021 Pipeline stage 1, on adv: SHALL register prod = in_data*p (signed 32), q, the filter tag and a valid bit (valid = transfer).
REQ-022 Pipeline stage 2, on adv: SHALL compute s = (prod + q) >>> FRAC (33-bit signed sum, arithmetic shift, floor) and saturate to [-32768, 32767].
REQ-023 Stage 2 SHALL register the result into out_data/out_filter and out_valid, giving a latency of 2 cycles from transfer to out_valid with no stall.
REQ-024 When adv=0, both pipeline stages SHALL hold their contents, so no output is lost or duplicated.
REQ-025 Stage 1 SHALL carry q with the product, so a reload of p/q in LOAD SHALL NOT corrupt in-flight samples.
REQ-026 DRAIN: SHALL enter FIN once both stage valid bits are 0.
REQ-027 FIN: SHALL assert done=1 for one cycle, then return to IDLE.
REQ-028 in_ready SHALL be 0 in IDLE, LOAD, DRAIN and FIN.
REQ-029 w_start SHALL be 0 outside LOAD.

Reset
REQ-030 rst=1 SHALL force IDLE, clear both counters and the p/q registers, and clear pipeline valid bits.
REQ-031 During reset: busy, done, w_start, in_ready, out_valid =0; w_filter, out_data, out_filter =0.
REQ-032 rst SHALL take priority over start and all handshakes; a reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-033 Bench SHALL check: NUM_FILTERS=1, LEN=1, p=16384, q=0, x=100 -> out_data=100, out_filter=0, done 1 cycle after the output transfer.
REQ-034 Bench SHALL check: p=10712, q=-28612, x=1000 -> 652; p=-190, q=721518, x=-32768 -> 424; p=1, q=0, x=-1 -> -1 (floor).
REQ-035 Bench SHALL check saturation: p=28571, q=-28612, x=32767 -> 32767; p=28571, q=0, x=-32768 -> -32768.
REQ-036 Bench SHALL check: default parameters, in_valid always 1, out_ready always 1 -> 640 outputs in order; w_filter steps 0..9; out_filter changes every 64 outputs; exactly one done.
REQ-037 Bench SHALL check: out_ready randomly 0 for 1-5 cycles -> output sequence identical to the no-stall run; in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-038 Bench SHALL check: rst pulse in RUN at filter 3 -> all outputs 0 next cycle, no done; a new start then runs from filter 0.
